// File: rtl/avalon_mm_line_capture_pkg.sv
// Shared definitions for the camera line-capture slave: register map offsets,
// control/status bit positions and the capture state encoding.
package avalon_mm_line_capture_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CAM_W  = 8;

    // Register offsets relative to the first word after both line buffers
    localparam int unsigned REG_CTRL        = 0;
    localparam int unsigned REG_STATUS      = 1;
    localparam int unsigned REG_LINE_LEN    = 2;
    localparam int unsigned REG_LINE_COUNT  = 3;
    localparam int unsigned REG_FRAME_COUNT = 4;

    localparam int unsigned CTRL_ENABLE    = 0;
    localparam int unsigned CTRL_IRQ_EN    = 1;
    localparam int unsigned CTRL_BYTE_SWAP = 2;

    localparam int unsigned ST_BUF0_FULL = 0;
    localparam int unsigned ST_BUF1_FULL = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_BUSY      = 3;
    localparam int unsigned ST_WR_SEL    = 4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_WAIT_LINE  = 3'd2,
        S_CAPTURE    = 3'd3,
        S_DROP       = 3'd4
    } state_e;

endpackage

// File: rtl/avalon_mm_line_capture_ram.sv
// Simple dual-port pixel RAM: camera write port, registered bus read port.
// Read-during-write to the same word returns the old contents.
module line_buffer_ram #(
    parameter int unsigned DEPTH = 1280,
    parameter int unsigned AW    = 11,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/avalon_mm_line_capture.sv
// Avalon-MM camera line-capture slave: packs byte-serial pixels into two
// ping-pong line buffers with host ownership handshake, counters and irq.
module avalon_mm_line_capture
    import avalon_mm_line_capture_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    output logic [15:0]       readdata,
    input  logic              write,
    input  logic [15:0]       writedata,
    input  logic              cam_pclk_en,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    output logic              irq
);

    localparam int unsigned BUF_WORDS = 2 * LINE_PIXELS;
    localparam int unsigned RAM_AW    = $clog2(BUF_WORDS);

    state_e              state_q, state_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [1:0]          full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                wr_sel_q, wr_sel_d;
    logic [15:0]         line_len_q, line_len_d;
    logic [15:0]         line_cnt_q, line_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         pix_cnt_q, pix_cnt_d;
    logic                phase_q, phase_d;
    logic [CAM_W-1:0]    byte_hi_q, byte_hi_d;
    logic                hs_prev_q, hs_prev_d;
    logic                vs_prev_q, vs_prev_d;
    logic                irq_q, irq_d;
    logic [DATA_W-1:0]   reg_rdata_q, reg_rdata_d;
    logic                rd_ram_q, rd_ram_d;

    logic                in_buf_c, hs_rise_c, hs_fall_c, vs_fall_c;
    logic                ctrl_wr_c, status_wr_c;
    logic [ADDR_W-1:0]   reg_off_c;
    logic [DATA_W-1:0]   reg_mux_c, ram_rdata_c, ram_wdata_c;
    logic                ram_we_c;
    logic [RAM_AW-1:0]   ram_waddr_c;
    logic                unused_wdata_c;

    assign in_buf_c    = address < ADDR_W'(BUF_WORDS);
    assign reg_off_c   = address - ADDR_W'(BUF_WORDS);
    assign ctrl_wr_c   = write && !in_buf_c && (reg_off_c == ADDR_W'(REG_CTRL));
    assign status_wr_c = write && !in_buf_c && (reg_off_c == ADDR_W'(REG_STATUS));
    assign hs_rise_c   = cam_pclk_en &&  cam_hsync && !hs_prev_q;
    assign hs_fall_c   = cam_pclk_en && !cam_hsync &&  hs_prev_q;
    assign vs_fall_c   = cam_pclk_en && !cam_vsync &&  vs_prev_q;
    assign unused_wdata_c = ^writedata[15:3];

    // Register read mux, sampled only on a register read
    always_comb begin
        reg_mux_c = '0;
        if (!in_buf_c) begin
            if (reg_off_c == ADDR_W'(REG_CTRL))        reg_mux_c = DATA_W'(ctrl_q);
            if (reg_off_c == ADDR_W'(REG_STATUS))      reg_mux_c = DATA_W'({wr_sel_q, state_q == S_CAPTURE, ovf_q, full_q});
            if (reg_off_c == ADDR_W'(REG_LINE_LEN))    reg_mux_c = line_len_q;
            if (reg_off_c == ADDR_W'(REG_LINE_COUNT))  reg_mux_c = line_cnt_q;
            if (reg_off_c == ADDR_W'(REG_FRAME_COUNT)) reg_mux_c = frame_cnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        wr_sel_d    = wr_sel_q;
        line_len_d  = line_len_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        phase_d     = phase_q;
        byte_hi_d   = byte_hi_q;
        hs_prev_d   = cam_pclk_en ? cam_hsync : hs_prev_q;
        vs_prev_d   = cam_pclk_en ? cam_vsync : vs_prev_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = wr_sel_q ? RAM_AW'(LINE_PIXELS) + RAM_AW'(pix_cnt_q) : RAM_AW'(pix_cnt_q);
        ram_wdata_c = ctrl_q[CTRL_BYTE_SWAP] ? {cam_data, byte_hi_q} : {byte_hi_q, cam_data};
        rd_ram_d    = read ? in_buf_c : rd_ram_q;
        reg_rdata_d = (read && !in_buf_c) ? reg_mux_c : reg_rdata_q;
        irq_d       = ctrl_q[CTRL_IRQ_EN] && (|full_q || ovf_q);

        // Host side first so that a same-cycle capture set overrides a W1C
        if (ctrl_wr_c) ctrl_d = writedata[2:0];
        if (status_wr_c) begin
            full_d = full_q & ~writedata[1:0];
            ovf_d  = ovf_q & ~writedata[ST_OVERFLOW];
        end

        if (!ctrl_q[CTRL_ENABLE]) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_WAIT_FRAME;
                S_WAIT_FRAME: begin
                    if (vs_fall_c) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        line_cnt_d  = '0;
                        state_d     = S_WAIT_LINE;
                    end
                end
                S_WAIT_LINE, S_CAPTURE, S_DROP: begin
                    if (vs_fall_c) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        line_cnt_d  = '0;
                        state_d     = S_WAIT_LINE;
                    end else if (state_q == S_WAIT_LINE) begin
                        if (hs_rise_c && full_q[wr_sel_q]) begin
                            ovf_d   = 1'b1;
                            state_d = S_DROP;
                        end else if (hs_rise_c) begin
                            pix_cnt_d = '0;
                            phase_d   = 1'b1;
                            byte_hi_d = cam_data;
                            state_d   = S_CAPTURE;
                        end
                    end else if (hs_fall_c) begin
                        line_cnt_d = line_cnt_q + 16'd1;
                        state_d    = S_WAIT_LINE;
                        if (state_q == S_CAPTURE) begin
                            full_d[wr_sel_q] = 1'b1;
                            line_len_d       = pix_cnt_q;
                            wr_sel_d         = !wr_sel_q;
                        end
                    end else if (state_q == S_CAPTURE && cam_pclk_en && cam_hsync) begin
                        phase_d = !phase_q;
                        if (!phase_q) begin
                            byte_hi_d = cam_data;
                        end else if (pix_cnt_q < 16'(LINE_PIXELS)) begin
                            ram_we_c  = 1'b1;
                            pix_cnt_d = pix_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            full_q      <= '0;
            ovf_q       <= 1'b0;
            wr_sel_q    <= 1'b0;
            line_len_q  <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            pix_cnt_q   <= '0;
            phase_q     <= 1'b0;
            byte_hi_q   <= '0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            irq_q       <= 1'b0;
            reg_rdata_q <= '0;
            rd_ram_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            wr_sel_q    <= wr_sel_d;
            line_len_q  <= line_len_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            phase_q     <= phase_d;
            byte_hi_q   <= byte_hi_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            irq_q       <= irq_d;
            reg_rdata_q <= reg_rdata_d;
            rd_ram_q    <= rd_ram_d;
        end
    end

    line_buffer_ram #(
        .DEPTH (BUF_WORDS),
        .AW    (RAM_AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .re    (read && in_buf_c),
        .raddr (RAM_AW'(address)),
        .rdata (ram_rdata_c)
    );

    assign readdata = rd_ram_q ? ram_rdata_c : reg_rdata_q;
    assign irq      = irq_q;

endmodule
